// File: rtl/axis_arb_user_sq_if.sv
// Bundle of the send-request and send-data channels around axis_arb_user_sq.
// The "slave" modport is the arbiter's view. The "master" modport is the view
// of the user sources and the downstream consumer that surround it.
interface axis_arb_user_sq_if #(
    parameter int N_SRCS    = 4,
    parameter int SRC_BITS  = (N_SRCS > 1) ? $clog2(N_SRCS) : 1,
    parameter int DATA_BITS = 512,
    parameter int LEN_BITS  = 28,
    parameter int PID_BITS  = 6,
    parameter int DEST_BITS = 4,
    parameter int OPC_BITS  = 5
);
    localparam int KEEP_BITS = DATA_BITS / 8;

    // Per-source request channel
    logic [N_SRCS-1:0]                s_rq_valid;
    logic [N_SRCS-1:0]                s_rq_ready;
    logic [N_SRCS-1:0][OPC_BITS-1:0]  s_rq_opcode;
    logic [N_SRCS-1:0][PID_BITS-1:0]  s_rq_pid;
    logic [N_SRCS-1:0][DEST_BITS-1:0] s_rq_dest;
    logic [N_SRCS-1:0][LEN_BITS-1:0]  s_rq_len;

    // Merged request channel
    logic                 m_rq_valid;
    logic                 m_rq_ready;
    logic [OPC_BITS-1:0]  m_rq_opcode;
    logic [PID_BITS-1:0]  m_rq_pid;
    logic [DEST_BITS-1:0] m_rq_dest;
    logic [LEN_BITS-1:0]  m_rq_len;
    logic [SRC_BITS-1:0]  m_rq_src;

    // Per-source data streams
    logic [N_SRCS-1:0]                s_axis_tvalid;
    logic [N_SRCS-1:0]                s_axis_tready;
    logic [N_SRCS-1:0]                s_axis_tlast;
    logic [N_SRCS-1:0][DATA_BITS-1:0] s_axis_tdata;
    logic [N_SRCS-1:0][KEEP_BITS-1:0] s_axis_tkeep;

    // Merged data stream
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic [DATA_BITS-1:0] m_axis_tdata;
    logic [KEEP_BITS-1:0] m_axis_tkeep;
    logic [SRC_BITS-1:0]  m_axis_tid;

    modport slave (
        input  s_rq_valid, s_rq_opcode, s_rq_pid, s_rq_dest, s_rq_len,
        output s_rq_ready,
        output m_rq_valid, m_rq_opcode, m_rq_pid, m_rq_dest, m_rq_len, m_rq_src,
        input  m_rq_ready,
        input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tid,
        input  m_axis_tready
    );

    modport master (
        output s_rq_valid, s_rq_opcode, s_rq_pid, s_rq_dest, s_rq_len,
        input  s_rq_ready,
        input  m_rq_valid, m_rq_opcode, m_rq_pid, m_rq_dest, m_rq_len, m_rq_src,
        output m_rq_ready,
        output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tid,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_arb_user_sq.sv
// Round-robin arbiter for user send requests. The winner's request is pushed
// into a 2-entry request FIFO. The data path stays locked to the granted
// source until its beat count is exhausted, and every beat is tagged with the
// source index.
// Optional build macro AXIS_ARB_TLAST_GEN_EN: when defined, m_axis_tlast is
// regenerated from the beat count instead of passing the upstream tlast.
module axis_arb_user_sq #(
    parameter int N_SRCS        = 4,
    parameter int SRC_BITS      = (N_SRCS > 1) ? $clog2(N_SRCS) : 1,
    parameter int DATA_BITS     = 512,
    parameter int BEAT_LOG_BITS = 6,
    parameter int LEN_BITS      = 28,
    parameter int PID_BITS      = 6,
    parameter int DEST_BITS     = 4,
    parameter int OPC_BITS      = 5
) (
    input logic                aclk,
    input logic                aresetn,
    axis_arb_user_sq_if.slave  bus
);
    localparam int CNT_BITS = LEN_BITS - BEAT_LOG_BITS;
    localparam int IW       = SRC_BITS + 1;

    typedef enum logic {ST_IDLE, ST_MUX} state_t;

    typedef struct packed {
        logic [OPC_BITS-1:0]  opcode;
        logic [PID_BITS-1:0]  pid;
        logic [DEST_BITS-1:0] dest;
        logic [LEN_BITS-1:0]  len;
        logic [SRC_BITS-1:0]  src;
    } rq_t;

    state_t              state_q, state_d;
    logic [SRC_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_BITS-1:0] src_q, src_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                run_q;        // low during reset and the first cycle after it

    rq_t                 fifo_q [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          fcnt_q;

    logic                cand_vld;
    logic [SRC_BITS-1:0] cand_idx;
    logic [LEN_BITS-1:0] cand_len;
    logic [LEN_BITS-1:0] cand_len_m1;
    logic                space, grant, xfer, tr_done, push, pop;
    rq_t                 push_entry, head;

    assign space       = (fcnt_q != 2'd2);
    assign xfer        = bus.m_axis_tvalid & bus.m_axis_tready;
    assign tr_done     = xfer & (cnt_q == '0);
    assign cand_len    = bus.s_rq_len[cand_idx];
    assign cand_len_m1 = cand_len - LEN_BITS'(1);
    assign grant       = aresetn & run_q & cand_vld & space &
                         ((state_q == ST_IDLE) | ((state_q == ST_MUX) & tr_done));
    assign push        = grant;
    assign pop         = bus.m_rq_valid & bus.m_rq_ready;

    // First requesting source at or after rr_ptr, wrapping modulo N_SRCS
    always_comb begin
        logic [IW-1:0] scan;
        cand_vld = 1'b0;
        cand_idx = '0;
        scan     = '0;
        for (int k = 0; k < N_SRCS; k++) begin
            scan = {1'b0, rr_ptr_q} + IW'(k);
            if (scan >= IW'(N_SRCS))
                scan = scan - IW'(N_SRCS);
            if (!cand_vld && bus.s_rq_valid[scan[SRC_BITS-1:0]]) begin
                cand_vld = 1'b1;
                cand_idx = scan[SRC_BITS-1:0];
            end
        end
    end

    // One-hot accept towards the granted source only
    always_comb begin
        bus.s_rq_ready = '0;
        if (grant)
            bus.s_rq_ready[cand_idx] = 1'b1;
    end

    assign push_entry.opcode = bus.s_rq_opcode[cand_idx];
    assign push_entry.pid    = bus.s_rq_pid[cand_idx];
    assign push_entry.dest   = bus.s_rq_dest[cand_idx];
    assign push_entry.len    = cand_len;
    assign push_entry.src    = cand_idx;

    // Control state: FSM, round-robin pointer and post-reset hold-off
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            run_q    <= 1'b1;
        end
    end

    // Burst owner and remaining-beat counter; meaningful only in ST_MUX
    always_ff @(posedge aclk) begin
        src_q <= src_d;
        cnt_q <= cnt_d;
    end

    // Next state: beat accounting, burst end, and back-to-back reload on grant
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        src_d    = src_q;
        cnt_d    = cnt_q;
        if (xfer && (cnt_q != '0))
            cnt_d = cnt_q - CNT_BITS'(1);
        if (tr_done)
            state_d = ST_IDLE;
        if (grant) begin
            rr_ptr_d = (cand_idx == SRC_BITS'(N_SRCS - 1)) ? '0 : cand_idx + SRC_BITS'(1);
            if (cand_len != '0) begin
                state_d = ST_MUX;
                src_d   = cand_idx;
                cnt_d   = CNT_BITS'(cand_len_m1 >> BEAT_LOG_BITS);
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Request FIFO occupancy and pointers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fcnt_q   <= 2'd0;
        end else begin
            if (push)
                wr_ptr_q <= ~wr_ptr_q;
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 2'd1;
                2'b01:   fcnt_q <= fcnt_q - 2'd1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    // Request FIFO storage
    always_ff @(posedge aclk) begin
        if (push)
            fifo_q[wr_ptr_q] <= push_entry;
    end

    assign head            = fifo_q[rd_ptr_q];
    assign bus.m_rq_valid  = aresetn & (fcnt_q != 2'd0);
    assign bus.m_rq_opcode = head.opcode;
    assign bus.m_rq_pid    = head.pid;
    assign bus.m_rq_dest   = head.dest;
    assign bus.m_rq_len    = head.len;
    assign bus.m_rq_src    = head.src;

    // Data path steering: only the locked source sees tready while in ST_MUX
    always_comb begin
        bus.m_axis_tvalid = 1'b0;
        bus.s_axis_tready = '0;
        if (aresetn && (state_q == ST_MUX)) begin
            bus.m_axis_tvalid        = bus.s_axis_tvalid[src_q];
            bus.s_axis_tready[src_q] = bus.m_axis_tready;
        end
    end

    assign bus.m_axis_tdata = bus.s_axis_tdata[src_q];
    assign bus.m_axis_tkeep = bus.s_axis_tkeep[src_q];
    assign bus.m_axis_tid   = src_q;

`ifdef AXIS_ARB_TLAST_GEN_EN
    assign bus.m_axis_tlast = (cnt_q == '0);
`else
    assign bus.m_axis_tlast = bus.s_axis_tlast[src_q];
`endif

endmodule

// File: tb/tb_axis_arb_user_sq.sv
// Directed bench for axis_arb_user_sq: a per-cycle vector table for
// arbitration, FIFO back-pressure, zero-length requests, stalls and reset,
// plus a hand-written tlast sequence.
module tb_axis_arb_user_sq;
    localparam int N    = 4;
    localparam int SB   = 2;
    localparam int DB   = 512;
    localparam int LB   = 28;
    localparam int KB   = DB / 8;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    always #5 aclk = ~aclk;

    axis_arb_user_sq_if #(.N_SRCS(N), .SRC_BITS(SB), .DATA_BITS(DB), .LEN_BITS(LB),
                          .PID_BITS(6), .DEST_BITS(4), .OPC_BITS(5)) bus ();

    axis_arb_user_sq #(.N_SRCS(N), .SRC_BITS(SB), .DATA_BITS(DB), .BEAT_LOG_BITS(6),
                       .LEN_BITS(LB), .PID_BITS(6), .DEST_BITS(4), .OPC_BITS(5)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    typedef struct {
        logic          rstn;
        logic [3:0]    rqv;
        logic [LB-1:0] len;
        logic          mrqr;
        logic [3:0]    tv;
        logic          mtr;
        logic [3:0]    e_rqr;
        logic          e_mrqv;
        logic [SB-1:0] e_msrc;
        logic [LB-1:0] e_len;
        logic          e_mtv;
        logic [SB-1:0] e_tid;
        logic [3:0]    e_tr;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic rstn, input logic [3:0] rqv, input int len,
                       input logic mrqr, input logic [3:0] tv, input logic mtr,
                       input logic [3:0] e_rqr, input logic e_mrqv, input int e_msrc,
                       input int e_len, input logic e_mtv, input int e_tid,
                       input logic [3:0] e_tr);
        vec_t v;
        v.rstn = rstn;   v.rqv = rqv;       v.len = LB'(len);
        v.mrqr = mrqr;   v.tv = tv;         v.mtr = mtr;
        v.e_rqr = e_rqr; v.e_mrqv = e_mrqv; v.e_msrc = SB'(e_msrc);
        v.e_len = LB'(e_len); v.e_mtv = e_mtv; v.e_tid = SB'(e_tid);
        v.e_tr = e_tr;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [DB-1:0] exp_data;
    logic [2:0]    tl_exp;

    initial begin
        // Static per-source fields: opcode=i, pid=i+4, dest=i, distinct data/keep
        bus.s_rq_valid    = '0;
        bus.m_rq_ready    = 1'b0;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        bus.m_axis_tready = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.s_rq_opcode[i]  = 5'(i);
            bus.s_rq_pid[i]     = 6'(i + 4);
            bus.s_rq_dest[i]    = 4'(i);
            bus.s_rq_len[i]     = '0;
            bus.s_axis_tdata[i] = {32{16'hA0B0 + 16'(i)}};
            bus.s_axis_tkeep[i] = KB'(64'(i + 1) * 64'h0101_0101_0101_0101);
        end

        // Single request src1, len=128 -> 2 beats
        add(0,4'b0010,128,1,4'b0000,1, 4'b0000,0,0,0,   0,0,4'b0000);
        add(0,4'b0010,128,1,4'b0000,1, 4'b0000,0,0,0,   0,0,4'b0000);
        add(1,4'b0010,128,1,4'b0000,1, 4'b0000,0,0,0,   0,0,4'b0000);
        add(1,4'b0010,128,1,4'b0000,1, 4'b0010,0,0,0,   0,0,4'b0000);
        add(1,4'b0000,128,1,4'b0010,1, 4'b0000,1,1,128, 1,1,4'b0010);
        add(1,4'b0000,128,1,4'b0010,1, 4'b0000,0,0,0,   1,1,4'b0010);
        add(1,4'b0000,128,1,4'b0010,1, 4'b0000,0,0,0,   0,0,4'b0000);
        // All sources, len=64, rr restarted at 0: grants 0,1,2,3,0 back to back
        add(0,4'b1111,64,1,4'b1111,1,  4'b0000,0,0,0,   0,0,4'b0000);
        add(1,4'b1111,64,1,4'b1111,1,  4'b0000,0,0,0,   0,0,4'b0000);
        add(1,4'b1111,64,1,4'b1111,1,  4'b0001,0,0,0,   0,0,4'b0000);
        add(1,4'b1111,64,1,4'b1111,1,  4'b0010,1,0,64,  1,0,4'b0001);
        add(1,4'b1111,64,1,4'b1111,1,  4'b0100,1,1,64,  1,1,4'b0010);
        add(1,4'b1111,64,1,4'b1111,1,  4'b1000,1,2,64,  1,2,4'b0100);
        add(1,4'b1111,64,1,4'b1111,1,  4'b0001,1,3,64,  1,3,4'b1000);
        add(1,4'b0000,64,1,4'b1111,1,  4'b0000,1,0,64,  1,0,4'b0001);
        add(1,4'b0000,64,1,4'b0000,1,  4'b0000,0,0,0,   0,0,4'b0000);
        // m_rq_ready low: third src0 request stalls until the FIFO drains
        add(1,4'b0001,64,0,4'b0001,1,  4'b0001,0,0,0,   0,0,4'b0000);
        add(1,4'b0001,64,0,4'b0001,1,  4'b0001,1,0,64,  1,0,4'b0001);
        add(1,4'b0001,64,0,4'b0001,1,  4'b0000,1,0,64,  1,0,4'b0001);
        add(1,4'b0001,64,0,4'b0001,1,  4'b0000,1,0,64,  0,0,4'b0000);
        add(1,4'b0001,64,1,4'b0001,1,  4'b0000,1,0,64,  0,0,4'b0000);
        add(1,4'b0001,64,0,4'b0001,1,  4'b0001,1,0,64,  0,0,4'b0000);
        add(1,4'b0000,64,1,4'b0001,1,  4'b0000,1,0,64,  1,0,4'b0001);
        add(1,4'b0000,64,1,4'b0000,1,  4'b0000,1,0,64,  0,0,4'b0000);
        add(1,4'b0000,64,1,4'b0000,1,  4'b0000,0,0,0,   0,0,4'b0000);
        // src2 len=0 (no data phase), then src3 len=100 (2 beats)
        add(1,4'b0100,0,1,4'b0100,1,   4'b0100,0,0,0,   0,0,4'b0000);
        add(1,4'b1000,100,1,4'b1100,1, 4'b1000,1,2,0,   0,0,4'b0000);
        add(1,4'b0000,100,1,4'b1100,1, 4'b0000,1,3,100, 1,3,4'b1000);
        add(1,4'b0000,100,1,4'b1100,1, 4'b0000,0,0,0,   1,3,4'b1000);
        add(1,4'b0000,100,1,4'b1100,1, 4'b0000,0,0,0,   0,0,4'b0000);
        // src1 len=256 with m_axis_tready toggling: exactly 4 transfers
        add(1,4'b0010,256,1,4'b1111,1, 4'b0010,0,0,0,   0,0,4'b0000);
        add(1,4'b0000,256,1,4'b1111,1, 4'b0000,1,1,256, 1,1,4'b0010);
        add(1,4'b0000,256,1,4'b1111,0, 4'b0000,0,0,0,   1,1,4'b0000);
        add(1,4'b0000,256,1,4'b1111,1, 4'b0000,0,0,0,   1,1,4'b0010);
        add(1,4'b0000,256,1,4'b1111,0, 4'b0000,0,0,0,   1,1,4'b0000);
        add(1,4'b0000,256,1,4'b1111,1, 4'b0000,0,0,0,   1,1,4'b0010);
        add(1,4'b0000,256,1,4'b1111,0, 4'b0000,0,0,0,   1,1,4'b0000);
        add(1,4'b0000,256,1,4'b1111,1, 4'b0000,0,0,0,   1,1,4'b0010);
        add(1,4'b0000,256,1,4'b1111,1, 4'b0000,0,0,0,   0,0,4'b0000);
        // Same burst again, reset after beat 2 with a request still queued
        add(1,4'b0010,256,0,4'b1111,1, 4'b0010,0,0,0,   0,0,4'b0000);
        add(1,4'b0000,256,0,4'b1111,1, 4'b0000,1,1,256, 1,1,4'b0010);
        add(1,4'b0000,256,0,4'b1111,1, 4'b0000,1,1,256, 1,1,4'b0010);
        add(0,4'b0010,256,0,4'b1111,1, 4'b0000,0,0,0,   0,0,4'b0000);
        add(1,4'b0010,256,0,4'b1111,1, 4'b0000,0,0,0,   0,0,4'b0000);
        add(1,4'b0000,256,0,4'b1111,1, 4'b0000,0,0,0,   0,0,4'b0000);

        for (int n = 0; n < tbl.size(); n++) begin
            @(negedge aclk);
            aresetn           = tbl[n].rstn;
            bus.s_rq_valid    = tbl[n].rqv;
            bus.m_rq_ready    = tbl[n].mrqr;
            bus.s_axis_tvalid = tbl[n].tv;
            bus.m_axis_tready = tbl[n].mtr;
            for (int i = 0; i < N; i++)
                bus.s_rq_len[i] = tbl[n].len;
            #1;
            chk($sformatf("v%0d s_rq_ready", n), 64'(bus.s_rq_ready), 64'(tbl[n].e_rqr));
            chk($sformatf("v%0d m_rq_valid", n), 64'(bus.m_rq_valid), 64'(tbl[n].e_mrqv));
            if (tbl[n].e_mrqv) begin
                chk($sformatf("v%0d m_rq_src", n),    64'(bus.m_rq_src),    64'(tbl[n].e_msrc));
                chk($sformatf("v%0d m_rq_len", n),    64'(bus.m_rq_len),    64'(tbl[n].e_len));
                chk($sformatf("v%0d m_rq_pid", n),    64'(bus.m_rq_pid),    64'(tbl[n].e_msrc) + 64'd4);
                chk($sformatf("v%0d m_rq_opcode", n), 64'(bus.m_rq_opcode), 64'(tbl[n].e_msrc));
                chk($sformatf("v%0d m_rq_dest", n),   64'(bus.m_rq_dest),   64'(tbl[n].e_msrc));
            end
            chk($sformatf("v%0d m_axis_tvalid", n), 64'(bus.m_axis_tvalid), 64'(tbl[n].e_mtv));
            if (tbl[n].e_mtv)
                chk($sformatf("v%0d m_axis_tid", n), 64'(bus.m_axis_tid), 64'(tbl[n].e_tid));
            chk($sformatf("v%0d s_axis_tready", n), 64'(bus.s_axis_tready), 64'(tbl[n].e_tr));
        end

        // src0 len=192 (3 beats), upstream tlast asserted on the first beat only
`ifdef AXIS_ARB_TLAST_GEN_EN
        tl_exp = 3'b100;
`else
        tl_exp = 3'b001;
`endif
        exp_data = {32{16'hA0B0}};
        @(negedge aclk);
        bus.s_rq_valid    = 4'b0001;
        bus.m_rq_ready    = 1'b1;
        bus.s_axis_tvalid = 4'b0001;
        bus.m_axis_tready = 1'b1;
        bus.s_axis_tlast  = 4'b0000;
        for (int i = 0; i < N; i++)
            bus.s_rq_len[i] = LB'(192);
        #1;
        chk("tl grant", 64'(bus.s_rq_ready), 64'h1);
        for (int b = 0; b < 3; b++) begin
            @(negedge aclk);
            bus.s_rq_valid  = 4'b0000;
            bus.s_axis_tlast = (b == 0) ? 4'b0001 : 4'b0000;
            #1;
            chk($sformatf("tl b%0d tvalid", b), 64'(bus.m_axis_tvalid), 64'h1);
            chk($sformatf("tl b%0d tid", b),    64'(bus.m_axis_tid),    64'h0);
            chk($sformatf("tl b%0d tlast", b),  64'(bus.m_axis_tlast),  64'(tl_exp[b]));
            chk($sformatf("tl b%0d tdata_lo", b), bus.m_axis_tdata[63:0],    exp_data[63:0]);
            chk($sformatf("tl b%0d tdata_hi", b), bus.m_axis_tdata[511:448], exp_data[511:448]);
            chk($sformatf("tl b%0d tkeep", b),  bus.m_axis_tkeep, 64'h0101_0101_0101_0101);
        end
        @(negedge aclk);
        bus.s_axis_tlast = 4'b0000;
        #1;
        chk("tl idle tvalid", 64'(bus.m_axis_tvalid), 64'h0);
        chk("tl idle tready", 64'(bus.s_axis_tready), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_arb_user_sq.md
Name: axis_arb_user_sq

Overview:
- Send-path counterpart of the user read-request demux; sits upstream of the shared request/data channel that feeds the network/host stack.
- Arbitrates N_SRCS user send requests round-robin and forwards the winner's request to a single output request channel.
- Locks the data path to the granted source until that request's beats are transferred.
- Tags the output data with the source index.

Parameters:
- N_SRCS, 4: number of user sources; 1..16.
- SRC_BITS, clog2s(N_SRCS): source index width; minimum 1.
- DATA_BITS, 512: AXI4S data width.
- BEAT_LOG_BITS, 6: log2 of bytes per beat (DATA_BITS/8 = 64).
- LEN_BITS, 28: request length field width, in bytes.
- PID_BITS, 6: process id width.
- DEST_BITS, 4: destination field width.
- OPC_BITS, 5: opcode width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- s_rq_valid  in  N_SRCS  per-source request valid.
- s_rq_ready  out  N_SRCS  per-source request accept.
- s_rq_opcode  in  N_SRCS x OPC_BITS  opcode.
- s_rq_pid  in  N_SRCS x PID_BITS  pid.
- s_rq_dest  in  N_SRCS x DEST_BITS  dest.
- s_rq_len  in  N_SRCS x LEN_BITS  length in bytes.
- m_rq_valid, m_rq_ready  out/in  1  output request handshake.
- m_rq_opcode/pid/dest/len  out  same widths  forwarded request fields.
- m_rq_src  out  SRC_BITS  granted source index.
- s_axis_tvalid/tready/tlast  in/out/in  N_SRCS each  per-source data handshake.
- s_axis_tdata  in  N_SRCS x DATA_BITS  per-source data.
- s_axis_tkeep  in  N_SRCS x DATA_BITS/8  per-source keep.
- m_axis_tvalid/tready/tlast  out/in/out  1  merged data handshake.
- m_axis_tdata  out  DATA_BITS  merged data.
- m_axis_tkeep  out  DATA_BITS/8  merged keep.
- m_axis_tid  out  SRC_BITS  merged data source tag.

Behaviour:
- Reset: state=ST_IDLE, rr_ptr=0, output queue empty.
  - All of m_rq_valid, m_axis_tvalid, s_rq_ready, s_axis_tready are 0 while aresetn=0 and in the first cycle after.
  - src_C and cnt_C are don't-care.
- Request output queue: 2-entry FIFO. Data is registered; m_rq_valid rises 1 cycle after accept. "space" = FIFO not full.
- Arbitration:
  - Candidate = first i with s_rq_valid[i], scanning from rr_ptr upward, modulo N_SRCS.
  - Purely combinational; one grant per cycle.
  - On grant of source g: s_rq_ready[g]=1 (all others 0), push {fields, src=g} to the FIFO, rr_ptr <= (g+1) mod N_SRCS.
- Grant allowed only when the FIFO has space and one of:
  - state=ST_IDLE, or
  - state=ST_MUX with tr_done.
- On grant with len!=0: src_N=g, cnt_N=(len-1)>>BEAT_LOG_BITS, state_N=ST_MUX.
- On grant with len==0: request is forwarded, no data phase; state_N=ST_IDLE.
- ST_MUX data path:
  - m_axis_tvalid=s_axis_tvalid[src_C].
  - s_axis_tready[src_C]=m_axis_tready; all other s_axis_tready=0.
  - tdata, tkeep and tlast are taken from src_C; m_axis_tid=src_C.
- ST_IDLE data path: m_axis_tvalid=0 and all s_axis_tready=0.
- Beat accounting: xfer = m_axis_tvalid & m_axis_tready.
  - tr_done = xfer & (cnt_C==0).
  - On xfer with cnt_C!=0: cnt_C decrements.
- On tr_done:
  - If a grant occurs in the same cycle, load the new request (back-to-back, zero bubble).
  - Otherwise go to ST_IDLE.
- Data is never reordered. Data for a request may start before m_rq has been accepted downstream; the FIFO decouples the two.
- Upstream tlast is passed through unchanged. A mismatch between tlast and the count is not checked; the count alone ends the burst.
- Reset mid-burst drops the burst and the FIFO contents; sources re-present afterwards.
- Length arithmetic: len is unsigned. Examples: len=1..64 gives 1 beat; len=65 gives 2 beats.

Optional Feature:
- Macro: AXIS_ARB_TLAST_GEN_EN.
- Defined: m_axis_tlast = (cnt_C==0), regenerated from the count; upstream tlast is ignored.
- Undefined: m_axis_tlast = s_axis_tlast[src_C].

Test Plan:
- Single request, src1, len=128, pid=5, 2 beats at full rate:
  - m_rq shows src=1, pid=5, len=128, one cycle after accept.
  - m_axis_tid=1 on both beats; state returns to ST_IDLE after beat 2.
- All 4 sources request continuously, len=64 each, rr_ptr=0:
  - Grant order 0,1,2,3,0.
  - No idle cycle between bursts.
  - Exactly one s_rq_ready high per grant.
- m_rq_ready held 0 while src0 issues three len=64 requests:
  - First two accepted and their data flows.
  - Third stalls (s_rq_ready=0) until m_rq_ready=1 frees an entry.
- src2 request with len=0, then src3 request with len=100:
  - Both forwarded.
  - Only src3 data (2 beats) is accepted.
  - s_axis_tready[2] never asserted.
- m_axis_tready toggles 1/0 during a len=256 (4-beat) burst:
  - Exactly 4 transfers.
  - Count held on stalls.
  - Other sources' tready stay 0.
  - aresetn=0 after beat 2 forces all valids and readies to 0 and state to ST_IDLE.
- With AXIS_ARB_TLAST_GEN_EN, src0 drives tlast=1 on beat 1 of 3:
  - m_axis_tlast=0,0,1.
  - Without the macro: 1,0,0.
